// File: rtl/tlda_pkg.sv
// Shared TLDA definitions: arbiter state encodings and default bus widths.
package tlda_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam int TLDA_ADDR_W  = 32;
    localparam int TLDA_COLOR_W = 16;

endpackage

// File: rtl/tlda_pixel_arbiter_rr_picker.sv
// Combinational round-robin priority select.
// Searches upward from ptr with wrap and returns the first set request.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int cand;

    // Walk offsets from far to near so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % N;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/tlda_pixel_arbiter.sv
// Round-robin arbiter sharing the TLDA master write port among pixel
// producers, with per-requester burst lock.
module tlda_pixel_arbiter
    import tlda_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = TLDA_ADDR_W,
    parameter int COLOR_W = TLDA_COLOR_W,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_draw,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       draw_out,
    output logic [ADDR_W-1:0]          pixel_address_out,
    output logic [COLOR_W-1:0]         color_out,
    input  logic                       write_finish_in,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic [31:0]                pixel_count
);

    logic [0:0]         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   grant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COLOR_W-1:0] color_q;
    logic [31:0]        cnt_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               finish;
    logic [IDX_W-1:0]   next_ptr;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req   (req_draw),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign finish = (state_q == ST_ISSUE) & write_finish_in;

    // A held lock parks the pointer on the winner; a void lock falls through.
    always_comb begin
        next_ptr = '0;
        if (req_lock[grant_q])
            next_ptr = grant_q;
        else if (grant_q != IDX_W'(NUM_REQ - 1))
            next_ptr = grant_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            color_q  <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        addr_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        color_q <= req_color[pick_idx*COLOR_W +: COLOR_W];
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (write_finish_in) begin
                        cnt_q    <= cnt_q + 32'd1;
                        rr_ptr_q <= next_ptr;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_done = '0;
        if (finish)
            req_done[grant_q] = 1'b1;
    end

    // Gate draw in the finish cycle so the master cannot chain a stale pixel.
    assign draw_out          = (state_q == ST_ISSUE) & ~write_finish_in;
    assign busy              = (state_q == ST_ISSUE);
    assign pixel_address_out = addr_q;
    assign color_out         = color_q;
    assign grant_id          = grant_q;
    assign pixel_count       = cnt_q;

endmodule
